// File: rtl/cla_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla_pipe : pipelined carry-lookahead adder/subtractor, one group per stage |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module cla_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NGRP = WIDTH / BLOCK;

  logic             w_adv;
  logic             r_v [NGRP];
  logic [WIDTH-1:0] r_a [NGRP];
  logic [WIDTH-1:0] r_y [NGRP];
  logic             r_c [NGRP];
  logic [WIDTH-1:0] w_a_nxt [NGRP];
  logic             w_c_nxt [NGRP];
  logic             w_c_msb;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  // Every carry is a flat sum of products from the group carry-in.
  function automatic logic [BLOCK:0] f_carries(
    input logic [BLOCK-1:0] p,
    input logic [BLOCK-1:0] g,
    input logic             c0
  );
    logic [BLOCK:0] c;
    logic           term;
    logic           acc;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      term = c0;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = acc | term;
    end
    return c;
  endfunction

  assign w_adv    = !(r_out_valid && !out_ready);
  assign in_ready = w_adv;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    localparam int LSB = k * BLOCK;
    logic [BLOCK-1:0] w_p;
    logic [BLOCK-1:0] w_g;
    logic [BLOCK:0]   w_c;
    logic [WIDTH-1:0] w_word;

    // r_y[k] is pre-shifted so this stage's group always sits at the bottom.
    assign w_p = r_a[k][LSB +: BLOCK] ^ r_y[k][BLOCK-1:0];
    assign w_g = r_a[k][LSB +: BLOCK] & r_y[k][BLOCK-1:0];
    assign w_c = f_carries(w_p, w_g, r_c[k]);

    always_comb begin
      w_word               = r_a[k];
      w_word[LSB +: BLOCK] = w_p ^ w_c[BLOCK-1:0];
    end

    assign w_a_nxt[k] = w_word;
    assign w_c_nxt[k] = w_c[BLOCK];

    if (k == NGRP - 1) begin : g_msb
      assign w_c_msb = w_c[BLOCK-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NGRP; k++) r_v[k] <= 1'b0;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      r_a[0] <= x;
      r_y[0] <= sub ? ~y : y;
      r_c[0] <= sub | cin;
      for (int k = 1; k < NGRP; k++) begin
        r_v[k] <= r_v[k-1];
        r_a[k] <= w_a_nxt[k-1];
        r_y[k] <= r_y[k-1] >> BLOCK;
        r_c[k] <= w_c_nxt[k-1];
      end
      r_out_valid <= r_v[NGRP-1];
      // Result registers only load real items so bubbles leave them untouched.
      if (r_v[NGRP-1]) begin
        r_z    <= w_a_nxt[NGRP-1];
        r_cout <= w_c_nxt[NGRP-1];
        r_ovf  <= w_c_nxt[NGRP-1] ^ w_c_msb;
        r_zero <= (w_a_nxt[NGRP-1] == '0);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cla_pipe : directed self-checking bench for cla_pipe (16/4 and 8/8)     |
// | Rev 1.0     : initial release                                              |
// +----------------------------------------------------------------------------+
module tb_cla_pipe;
  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] x, y, z;
  logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready;
  logic        n_cout, n_ovf, n_zero;
  logic [7:0]  n_x, n_y, n_z;
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        s;
    logic [15:0] ez;
    logic        ec;
    logic        eo;
    logic        ezr;
  } vec_t;

  cla_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cout(cout), .ovf(ovf), .zero(zero)
  );

  cla_pipe #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .x(n_x), .y(n_y), .cin(n_cin), .sub(n_sub),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .z(n_z), .cout(n_cout), .ovf(n_ovf), .zero(n_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one item into the 16-bit DUT and waits for its result; lat counts edges incl. accept.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic s, output int lat);
    x = a; y = b; cin = ci; sub = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (z !== 16'h0000) begin failures++; $display("FAIL reset_z: got %h expected 0000", z); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b expected 0", zero); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_arith();
    vec_t v[5];
    int   lat;
    v[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    v[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    v[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op16(v[i].a, v[i].b, v[i].ci, v[i].s, lat);
      checks++; if (lat != 5) begin failures++; $display("FAIL arith[%0d] latency: got %0d expected 5", i, lat); end
      checks++; if (z !== v[i].ez) begin failures++; $display("FAIL arith[%0d] z: got %h expected %h", i, z, v[i].ez); end
      checks++; if (cout !== v[i].ec) begin failures++; $display("FAIL arith[%0d] cout: got %b expected %b", i, cout, v[i].ec); end
      checks++; if (ovf !== v[i].eo) begin failures++; $display("FAIL arith[%0d] ovf: got %b expected %b", i, ovf, v[i].eo); end
      checks++; if (zero !== v[i].ezr) begin failures++; $display("FAIL arith[%0d] zero: got %b expected %b", i, zero, v[i].ezr); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] xa[20], ya[20], yb;
    logic        sa[20], ca[20], eo[20];
    logic [16:0] ex[20];
    logic [15:0] zh;
    logic        acc;
    int          in_idx, out_idx, extra;
    for (int i = 0; i < 20; i++) begin
      xa[i] = 16'($urandom);
      ya[i] = 16'($urandom);
      sa[i] = 1'($urandom_range(0, 1));
      ca[i] = 1'($urandom_range(0, 1));
      yb    = sa[i] ? ~ya[i] : ya[i];
      ex[i] = sa[i] ? ({1'b0, xa[i]} + {1'b0, ~ya[i]} + 17'd1)
                    : ({1'b0, xa[i]} + {1'b0, ya[i]} + {16'd0, ca[i]});
      eo[i] = (xa[i][15] == yb[15]) && (ex[i][15] != xa[i][15]);
    end
    in_idx = 0; out_idx = 0; zh = '0;
    for (int cyc = 0; cyc < 200 && out_idx < 20; cyc++) begin
      in_valid = (in_idx < 20);
      if (in_idx < 20) begin
        x = xa[in_idx]; y = ya[in_idx]; sub = sa[in_idx]; cin = ca[in_idx];
      end
      out_ready = !(cyc >= 8 && cyc <= 10);
      #1;
      if (cyc == 8) zh = z;
      if (cyc >= 8 && cyc <= 10) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc %0d: got %b expected 0", cyc, in_ready); end
      end
      if (cyc >= 9 && cyc <= 11) begin
        checks++; if (z !== zh) begin failures++; $display("FAIL stall_z_hold cyc %0d: got %h expected %h", cyc, z, zh); end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++; if ({cout, z} !== ex[out_idx]) begin failures++; $display("FAIL stream[%0d] {cout,z}: got %h expected %h", out_idx, {cout, z}, ex[out_idx]); end
        checks++; if (ovf !== eo[out_idx]) begin failures++; $display("FAIL stream[%0d] ovf: got %b expected %b", out_idx, ovf, eo[out_idx]); end
        out_idx++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) in_idx++;
    end
    checks++; if (out_idx != 20) begin failures++; $display("FAIL stream_count: got %0d expected 20", out_idx); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid === 1'b1) extra++;
      step();
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL stream_duplicates: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_inflight();
    int seen;
    out_ready = 1'b1;
    sub = 1'b0; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = 16'h1111 * 16'(i + 1); y = 16'h0F0F; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL inflight_out_valid: got %b expected 0", out_valid); end
    checks++; if (z !== 16'h0000) begin failures++; $display("FAIL inflight_z: got %h expected 0000", z); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL inflight_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL inflight_ovf: got %b expected 0", ovf); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL inflight_zero: got %b expected 0", zero); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL inflight_in_ready: got %b expected 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL inflight_leak: got %0d results expected 0", seen); end
  endtask

  task automatic test_narrow();
    int lat;
    n_out_ready = 1'b1;
    n_x = 8'hF0; n_y = 8'h0F; n_cin = 1'b1; n_sub = 1'b0; n_in_valid = 1'b1;
    step();
    n_in_valid = 1'b0;
    lat = 1;
    while (n_out_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    checks++; if (lat != 2) begin failures++; $display("FAIL narrow_latency: got %0d expected 2", lat); end
    checks++; if (n_z !== 8'h00) begin failures++; $display("FAIL narrow_z: got %h expected 00", n_z); end
    checks++; if (n_cout !== 1'b1) begin failures++; $display("FAIL narrow_cout: got %b expected 1", n_cout); end
    checks++; if (n_zero !== 1'b1) begin failures++; $display("FAIL narrow_zero: got %b expected 1", n_zero); end
    checks++; if (n_ovf !== 1'b0) begin failures++; $display("FAIL narrow_ovf: got %b expected 0", n_ovf); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_x = '0; n_y = '0; n_cin = 1'b0; n_sub = 1'b0; n_out_ready = 1'b1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_inflight();
    test_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Successor to the fixed 4-bit combinational CLA. Width is generalised into NGRP = WIDTH/BLOCK lookahead groups, with one group resolved per pipeline stage.
- Adds subtract mode, carry-out and signed-overflow flags, a zero flag, and a valid/ready handshake with full back-pressure.
- Sits between operand registers and the result consumer in the datapath. Sustains one operation per cycle.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be an exact multiple of BLOCK.
- BLOCK, 4, bits per lookahead group (1..8). Group carry uses full lookahead from the incoming carry, not ripple.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  x, y, cin, sub valid this cycle
- in_ready  out  1  block accepts input this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- cin  in  1  carry-in (add mode only)
- sub  in  1  0: z = x + y + cin; 1: z = x - y (x + ~y + 1, cin ignored)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- z  out  WIDTH  sum/difference
- cout  out  1  carry out of MSB (in sub mode, 1 = no borrow)
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB
- zero  out  1  z == 0

Behaviour:
- Reset: synchronous on the rising clk edge while rst=1.
  - All stage valid bits, out_valid, z, cout, ovf and zero clear to 0.
  - in_ready is 1 from the first cycle after reset, since the pipeline is empty.
  - Data already in flight at reset is discarded; no result is emitted for it.
- Global advance: adv = !(out_valid && !out_ready).
  - in_ready = adv (combinational from out_valid and out_ready).
  - When adv=0, every stage register holds, including bubbles.
- Transfer rules:
  - Input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Operand preparation at acceptance:
  - Stage 0 register captures x, y' = sub ? ~y : y, and c0 = sub ? 1 : cin.
  - It also captures a valid bit equal to in_valid.
- Stage k (k = 0..NGRP-1) resolves group k, bits [k*BLOCK +: BLOCK]:
  - p_i = x_i ^ y'_i and g_i = x_i & y'_i.
  - Carry c_{i+1} uses lookahead: g_i | p_i&g_{i-1} | ... | p_i&...&p_base&c_in_group.
  - Sum bit z_i = p_i ^ c_i.
  - Resolved sum bits, the remaining operand bits and the group carry-out pass to stage k+1 registers.
  - Per-stage pass-through is the only ripple between groups.
- The final stage registers z, cout = carry out of bit WIDTH-1, ovf and zero, and sets out_valid from its valid bit.
- Latency: a result appears on the outputs exactly NGRP+1 rising edges after acceptance, when no stalls occur.
  - This is 5 cycles for the 16/4 default.
  - Throughput is 1/cycle.
- Bubbles (in_valid=0 while adv=1) propagate as invalid slots and never produce out_valid.
- Outputs hold stable while out_valid=1 and out_ready=0.
- When out_valid=1 and out_ready=1 on the same cycle as an accept, the pipeline advances normally with no lost or duplicated item.
- With out_ready tied to 1, in_ready stays 1 permanently.
- Wrap-around: z is the result modulo 2^WIDTH; carries beyond the MSB appear only on cout.
- BLOCK = WIDTH is legal: NGRP = 1, latency 2.

Test Plan:
- Defaults, rst held 2 cycles, out_ready=1, accept x=0x1234, y=0x4321, cin=1, sub=0 → 5 edges later out_valid=1, z=0x5556, cout=0, ovf=0, zero=0.
- x=0xFFFF, y=0x0001, cin=0, sub=0 → z=0x0000, cout=1, ovf=0, zero=1. Then x=0x7FFF, y=0x0001 → z=0x8000, ovf=1, cout=0.
- Subtract: x=0x0005, y=0x0007, sub=1, cin=1 (ignored) → z=0xFFFE, cout=0, ovf=0. Then x=0x8000, y=0x0001, sub=1 → z=0x7FFF, ovf=1, cout=1.
- Back-to-back stream of 20 random operand pairs with out_ready low for 3 cycles mid-stream → in_ready drops on the same cycles, and z holds. All 20 results emerge in order, each matching x±y, with no drops or duplicates.
- Assert rst with 3 items in flight → next cycle out_valid=0, z=0, cout/ovf/zero=0, in_ready=1. None of the 3 items ever appears.
- WIDTH=8, BLOCK=8: x=0xF0, y=0x0F, cin=1 → z=0x00, cout=1, zero=1, out_valid 2 edges after accept.
